// File: rtl/complete_stage_pkg.sv
// Shared types for the complete stage: FU result packets and the CDB, PRF and ROB views of them.
package complete_stage_pkg;

  localparam int XLEN         = 32;
  localparam int PR_IDX_W     = 6;
  localparam int ROB_IDX_W    = 5;
  localparam int DEF_CQ_DEPTH = 4;
  localparam int DEF_NUM_IN   = 2;

  typedef struct packed {
    logic                 valid;
    logic [PR_IDX_W-1:0]  pr_idx;
    logic [XLEN-1:0]      dest_value;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 take_branch;
    logic [XLEN-1:0]      target_pc;
  } FU_COMPLETE_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [PR_IDX_W-1:0]  pr_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
  } CDB_PACKET;

  typedef struct packed {
    logic [PR_IDX_W-1:0] idx;
    logic [XLEN-1:0]     value;
  } FU_PRF_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 take_branch;
    logic [XLEN-1:0]      target_pc;
  } COMPLETE_ROB_PACKET;

  // Physical register 0 is the "no destination" marker.
  function automatic logic has_dest(input FU_COMPLETE_PACKET p);
    return p.pr_idx != '0;
  endfunction

endpackage

// File: rtl/complete_stage_if.sv
// Bundle between the FU/LSU side and the complete stage, including its CDB/PRF/ROB outputs.
interface complete_stage_if
  import complete_stage_pkg::*;
#(
  parameter int CQ_DEPTH = DEF_CQ_DEPTH,
  parameter int NUM_IN   = DEF_NUM_IN
);
  FU_COMPLETE_PACKET                 fu_complete_in [NUM_IN];
  logic                              squash;
  CDB_PACKET                         cdb_out;
  FU_PRF_PACKET                      complete_prf_out;
  COMPLETE_ROB_PACKET                complete_rob_out;
  logic                              stall_complete;
  logic [$clog2(CQ_DEPTH+1)-1:0]     cq_count;
  logic                              overflow_err;

  modport master (
    output fu_complete_in, squash,
    input  cdb_out, complete_prf_out, complete_rob_out, stall_complete, cq_count, overflow_err
  );

  modport slave (
    input  fu_complete_in, squash,
    output cdb_out, complete_prf_out, complete_rob_out, stall_complete, cq_count, overflow_err
  );
endinterface

// File: rtl/complete_queue.sv
// Multi-write, single-read circular buffer; reports which input lanes found space this cycle.
module complete_queue
  import complete_stage_pkg::*;
#(
  parameter  int DEPTH  = DEF_CQ_DEPTH,
  parameter  int NUM_IN = DEF_NUM_IN,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  FU_COMPLETE_PACKET wr_pkt [NUM_IN],
  output FU_COMPLETE_PACKET head_pkt,
  output logic [CNT_W-1:0]  count,
  output logic [NUM_IN-1:0] accepted
);

  FU_COMPLETE_PACKET entries [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W-1:0]  wr_idx [NUM_IN];
  logic [CNT_W-1:0]  n_enq;
  logic              deq;

  assign deq      = (count != '0) && !flush;
  assign head_pkt = entries[head];

  // Space counts the slot freed by this cycle's dequeue; lanes claim slots in lane order.
  always_comb begin
    int space;
    int used;
    space    = DEPTH - int'(count) + int'(deq);
    used     = 0;
    accepted = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      wr_idx[i] = tail + PTR_W'(used);
      if (wr_pkt[i].valid && !flush && used < space) begin
        accepted[i] = 1'b1;
        used++;
      end
    end
    n_enq = CNT_W'(used);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: the entry array is cleared on reset too, so the head slot never holds stale data.
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++)
        if (accepted[i]) entries[wr_idx[i]] <= wr_pkt[i];
      head  <= head + PTR_W'(deq);
      tail  <= tail + PTR_W'(n_enq);
      count <= count + n_enq - CNT_W'(deq);
    end
  end

endmodule

// File: rtl/complete_stage.sv
// Complete stage: buffers FU/LSU results and retires one per cycle onto the CDB, PRF and ROB.
module complete_stage
  import complete_stage_pkg::*;
#(
  parameter int CQ_DEPTH = DEF_CQ_DEPTH,
  parameter int NUM_IN   = DEF_NUM_IN
) (
  input logic             clock,
  input logic             reset,
  complete_stage_if.slave cq
);

  localparam int CNT_W = $clog2(CQ_DEPTH + 1);

  FU_COMPLETE_PACKET head_pkt;
  logic [CNT_W-1:0]  count;
  logic [NUM_IN-1:0] accepted;
  logic [NUM_IN-1:0] lane_valid;
  logic              show;

  complete_queue #(.DEPTH(CQ_DEPTH), .NUM_IN(NUM_IN)) u_queue (
    .clock    (clock),
    .reset    (reset),
    .flush    (cq.squash),
    .wr_pkt   (cq.fu_complete_in),
    .head_pkt (head_pkt),
    .count    (count),
    .accepted (accepted)
  );

  always_comb begin
    lane_valid = '0;
    for (int i = 0; i < NUM_IN; i++) lane_valid[i] = cq.fu_complete_in[i].valid;
  end

  assign show = (count != '0) && !cq.squash && !reset;

  always_comb begin
    // NOTE: zero defaults first keep idle and squashed cycles clean and prevent inferred latches.
    cq.cdb_out          = '0;
    cq.complete_prf_out = '0;
    cq.complete_rob_out = '0;
    if (show) begin
      cq.complete_rob_out = '{valid: 1'b1, rob_idx: head_pkt.rob_idx,
                              take_branch: head_pkt.take_branch, target_pc: head_pkt.target_pc};
      if (has_dest(head_pkt)) begin
        cq.cdb_out          = '{valid: 1'b1, pr_idx: head_pkt.pr_idx, rob_idx: head_pkt.rob_idx};
        cq.complete_prf_out = '{idx: head_pkt.pr_idx, value: head_pkt.dest_value};
      end
    end
  end

  // Conservative: the dequeue happening this cycle is not credited to upstream.
  assign cq.stall_complete = (CQ_DEPTH - int'(count)) < NUM_IN;
  assign cq.cq_count       = count;

  always_ff @(posedge clock) begin
    if (reset)
      cq.overflow_err <= 1'b0;
    else if (!cq.squash && (lane_valid & ~accepted) != '0)
      cq.overflow_err <= 1'b1;
  end

endmodule

// File: tb/tb_complete_stage.sv
// Scoreboard bench for complete_stage: expected packets queue on drive and are matched at the outputs.
module tb_complete_stage;
  import complete_stage_pkg::*;

  localparam int CQ_DEPTH = 4;
  localparam int NUM_IN   = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  complete_stage_if #(.CQ_DEPTH(CQ_DEPTH), .NUM_IN(NUM_IN)) cq_if ();

  complete_stage #(.CQ_DEPTH(CQ_DEPTH), .NUM_IN(NUM_IN)) dut (
    .clock (clock),
    .reset (reset),
    .cq    (cq_if)
  );

  FU_COMPLETE_PACKET sb [$];
  int                n_checks = 0;
  int                n_pass   = 0;
  int                pending  = 0;
  logic              exp_ovf  = 1'b0;
  logic              mon_en   = 1'b0;
  FU_COMPLETE_PACKET none     = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic FU_COMPLETE_PACKET mk(input int pr, input logic [31:0] val, input int rob,
                                           input logic tb, input logic [31:0] tpc);
    FU_COMPLETE_PACKET p;
    p.valid       = 1'b1;
    p.pr_idx      = PR_IDX_W'(pr);
    p.dest_value  = val;
    p.rob_idx     = ROB_IDX_W'(rob);
    p.take_branch = tb;
    p.target_pc   = tpc;
    return p;
  endfunction

  // One cycle: check registered state, model acceptance, drive inputs, advance to posedge+1.
  task automatic drive(input FU_COMPLETE_PACKET p0, input FU_COMPLETE_PACKET p1,
                       input logic sq, input logic rst);
    FU_COMPLETE_PACKET lanes [2];
    int free;
    int n;
    check("cq_count", 64'(cq_if.cq_count), 64'(sb.size()));
    check("stall_complete", 64'(cq_if.stall_complete), 64'((CQ_DEPTH - sb.size()) < NUM_IN));
    check("overflow_err", 64'(cq_if.overflow_err), 64'(exp_ovf));
    lanes[0] = p0;
    lanes[1] = p1;
    pending  = 0;
    n        = 0;
    if (rst) begin
      sb.delete();
      exp_ovf = 1'b0;
    end else if (sq) begin
      sb.delete();
    end else begin
      free = CQ_DEPTH - sb.size() + ((sb.size() > 0) ? 1 : 0);
      for (int i = 0; i < NUM_IN; i++) begin
        if (lanes[i].valid) begin
          if (n < free) begin
            sb.push_back(lanes[i]);
            pending++;
            n++;
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
    end
    reset                   = rst;
    cq_if.fu_complete_in[0] = p0;
    cq_if.fu_complete_in[1] = p1;
    cq_if.squash            = sq;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(none, none, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle();
    idle();
  endtask

  FU_COMPLETE_PACKET mon_e;
  logic              mon_exp;

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      mon_exp = ((sb.size() - pending) > 0) && !cq_if.squash;
      check("rob_valid", 64'(cq_if.complete_rob_out.valid), 64'(mon_exp));
      if (!mon_exp) begin
        check("idle_cdb_prf", 64'({cq_if.cdb_out.valid, cq_if.complete_prf_out.idx}), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check("rob_out", 64'(cq_if.complete_rob_out),
              64'({1'b1, mon_e.rob_idx, mon_e.take_branch, mon_e.target_pc}));
        check("cdb_valid", 64'(cq_if.cdb_out.valid), 64'(mon_e.pr_idx != '0));
        check("prf_idx", 64'(cq_if.complete_prf_out.idx), 64'(mon_e.pr_idx));
        if (mon_e.pr_idx != '0) begin
          check("cdb_tags", 64'({cq_if.cdb_out.pr_idx, cq_if.cdb_out.rob_idx}),
                64'({mon_e.pr_idx, mon_e.rob_idx}));
          check("prf_value", 64'(cq_if.complete_prf_out.value), 64'(mon_e.dest_value));
        end
      end
    end
  end

  initial begin
    int nxt;
    cq_if.fu_complete_in[0] = '0;
    cq_if.fu_complete_in[1] = '0;
    cq_if.squash            = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    mon_en = 1'b1;

    // Reset then idle: everything quiet.
    for (int i = 0; i < 10; i++) begin
      check("idle_cdb", 64'(cq_if.cdb_out), 64'(0));
      check("idle_prf", 64'(cq_if.complete_prf_out), 64'(0));
      check("idle_rob", 64'(cq_if.complete_rob_out), 64'(0));
      idle();
    end

    // Single lane-0 packet.
    drive(mk(5, 32'h1234, 3, 1'b0, 32'h0), none, 1'b0, 1'b0);
    idle();
    idle();

    // Both lanes for three packet pairs, honouring stall.
    nxt = 1;
    for (int i = 0; i < 20 && nxt <= 6; i++) begin
      if (cq_if.stall_complete) idle();
      else begin
        drive(mk(nxt, 32'h100 + 32'(nxt), nxt, 1'b0, 32'h0),
              mk(nxt + 1, 32'h100 + 32'(nxt + 1), nxt + 1, 1'b0, 32'h0), 1'b0, 1'b0);
        nxt += 2;
      end
    end
    drain();

    // Destination-less packet still completes in the ROB.
    drive(mk(0, 32'h55, 7, 1'b1, 32'h80), none, 1'b0, 1'b0);
    drain();

    // Squash with three queued entries and two arriving packets.
    drive(mk(21, 32'h21, 21, 1'b0, 32'h0), mk(22, 32'h22, 22, 1'b0, 32'h0), 1'b0, 1'b0);
    drive(mk(23, 32'h23, 23, 1'b0, 32'h0), mk(24, 32'h24, 24, 1'b0, 32'h0), 1'b0, 1'b0);
    check("pre_squash_count", 64'(cq_if.cq_count), 64'(3));
    drive(mk(25, 32'h25, 25, 1'b0, 32'h0), mk(26, 32'h26, 26, 1'b0, 32'h0), 1'b1, 1'b0);
    repeat (4) idle();

    // Wrap-around: nine single packets, each followed by an idle cycle.
    for (int i = 0; i < 9; i++) begin
      drive(mk(31 + i, 32'hA000 + 32'(i), i, i[0], 32'h400 + 32'(i)), none, 1'b0, 1'b0);
      idle();
    end
    drain();

    // Upstream ignores stall: fourth pair finds one slot, lane 1 dropped.
    for (int i = 0; i < 4; i++)
      drive(mk(11 + 2 * i, 32'hB0 + 32'(i), 11 + 2 * i, 1'b0, 32'h0),
            mk(12 + 2 * i, 32'hC0 + 32'(i), 12 + 2 * i, 1'b1, 32'h200), 1'b0, 1'b0);
    drain();

    // Reset mid-operation with two entries queued.
    drive(mk(41, 32'h41, 9, 1'b0, 32'h0), mk(42, 32'h42, 10, 1'b0, 32'h0), 1'b0, 1'b0);
    drive(mk(43, 32'h43, 11, 1'b0, 32'h0), none, 1'b0, 1'b0);
    drive(none, none, 1'b0, 1'b1);
    check("post_reset_cdb", 64'(cq_if.cdb_out), 64'(0));
    check("post_reset_prf", 64'(cq_if.complete_prf_out), 64'(0));
    check("post_reset_rob", 64'(cq_if.complete_rob_out), 64'(0));
    repeat (3) idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
